// File: rtl/video_clk_pkg.sv
// Shared types and elaboration helpers for the NCO-based video clock-enable generator.
package video_clk_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } vclk_state_t;

    // Increment that produces num/den pulses per refclk cycle on an acc_w-bit accumulator.
    function automatic logic [63:0] calc_inc(input int unsigned num,
                                             input int unsigned den,
                                             input int          acc_w);
        logic [63:0] scaled;
        scaled = 64'(num) << acc_w;
        if (den == 0) begin
            return '0;
        end
        return scaled / 64'(den);
    endfunction

    // Width of a down-counter that must hold the value SETTLE_CYCLES.
    function automatic int settle_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/video_nco_ch.sv
// One NCO channel: phase accumulator with carry-out enable pulse and MSB strobe.
module video_nco_ch
    import video_clk_pkg::*;
#(
    parameter int               ACC_W   = 32,
    parameter logic [ACC_W-1:0] DEF_INC = ACC_W'(calc_inc(1, 2, ACC_W))
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
    output logic             en_out,
    output logic             sq_out,
    output logic             active
);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] inc_reg;
    logic             en_reg;
    logic             sq_reg;
    logic [ACC_W:0]   sum_next;

    assign sum_next = {1'b0, acc_reg} + {1'b0, inc_reg};

    // A load replaces the accumulate for that edge, so the new phase is exact.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            inc_reg <= DEF_INC;
            en_reg  <= 1'b0;
            sq_reg  <= 1'b0;
        end else if (load) begin
            inc_reg <= load_inc;
            acc_reg <= load_phase;
            en_reg  <= 1'b0;
            sq_reg  <= load_phase[ACC_W-1];
        end else if (inc_reg != '0) begin
            acc_reg <= sum_next[ACC_W-1:0];
            en_reg  <= sum_next[ACC_W];
            sq_reg  <= sum_next[ACC_W-1];
        end else begin
            en_reg  <= 1'b0;
        end
    end

    assign en_out = en_reg;
    assign sq_out = sq_reg;
    assign active = (inc_reg != '0);

endmodule

// File: rtl/video_clk_en_gen.sv
// NUM_CH clock-enable generators on refclk with a settle/lock sequencer and
// a valid/ready port for reprogramming rate and phase of one channel at a time.
module video_clk_en_gen
    import video_clk_pkg::*;
#(
    parameter int               NUM_CH        = 3,
    parameter int               ACC_W         = 32,
    parameter int               SETTLE_CYCLES = 1024,
    parameter logic [ACC_W-1:0] DEF_INC       = ACC_W'(calc_inc(1, 2, ACC_W)),
    localparam int              CH_W          = ch_idx_w(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] en_out,
    output logic [NUM_CH-1:0] sq_out,
    output logic [NUM_CH-1:0] ch_active,
    output logic              locked
);

    localparam int CNT_W = settle_cnt_w(SETTLE_CYCLES);

    vclk_state_t      state_reg;
    logic [CNT_W-1:0] settle_cnt_reg;
    logic             accept;
    logic             ch_in_range;
    logic [NUM_CH-1:0] load_vec;

    // cfg_ready is a pure state decode, so accept never depends combinationally on itself.
    assign cfg_ready   = (state_reg == LOCKED);
    assign locked      = (state_reg == LOCKED);
    assign accept      = cfg_valid && cfg_ready;
    assign ch_in_range = (32'(cfg_ch) < 32'(NUM_CH));

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg      <= SETTLE;
            settle_cnt_reg <= CNT_W'(SETTLE_CYCLES);
        end else begin
            case (state_reg)
                SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg - CNT_W'(1);
                    if (settle_cnt_reg == CNT_W'(1)) begin
                        state_reg <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Out-of-range channel requests are consumed without effect.
                    if (accept && ch_in_range) begin
                        state_reg      <= SETTLE;
                        settle_cnt_reg <= CNT_W'(SETTLE_CYCLES);
                    end
                end
                default: begin
                    state_reg      <= SETTLE;
                    settle_cnt_reg <= CNT_W'(SETTLE_CYCLES);
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign load_vec[gi] = accept && (cfg_ch == CH_W'(gi));

            video_nco_ch #(
                .ACC_W   (ACC_W),
                .DEF_INC (DEF_INC)
            ) u_nco (
                .refclk     (refclk),
                .rst        (rst),
                .load       (load_vec[gi]),
                .load_inc   (cfg_inc),
                .load_phase (cfg_phase),
                .en_out     (en_out[gi]),
                .sq_out     (sq_out[gi]),
                .active     (ch_active[gi])
            );
        end
    endgenerate

endmodule
